digit_serial_adder: RTL
=======================

# digit_serial_adder

Parametrised multi-bit adder that processes a WIDTH-bit addition DIGIT bits per clock. It uses an internal ripple chain of full-adder cells and a registered carry between digits. Operands are accepted and results returned over valid/ready handshakes. It is the sequential, area-reduced successor to the single-bit dataflow full adder, for datapaths where WIDTH-bit ripple logic per cycle is too large.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1.
- DIGIT, 4, bits summed per cycle; must be ≥ 1 and divide WIDTH exactly, otherwise elaboration fails.
- NDIG is derived, not overridable: NDIG = WIDTH/DIGIT.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, operands a, b, cin are valid.
- in_ready, out, 1, block can accept operands; high only in IDLE.
- a, in, WIDTH, addend.
- b, in, WIDTH, addend.
- cin, in, 1, carry-in to bit 0.
- out_valid, out, 1, sum and cout are valid.
- out_ready, in, 1, consumer accepts the result.
- sum, out, WIDTH, result a+b+cin mod 2^WIDTH.
- cout, out, 1, carry out of bit WIDTH-1.
- busy, out, 1, high in RUN or DONE.
- sub, in, 1, subtract select; present only with SERIAL_ADD_SUB_EN.
- ovf, out, 1, signed overflow; present only with SERIAL_ADD_SUB_EN.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh←a, b_sh←b, carry←cin, digit count←0, then go to RUN.
- RUN, once per cycle:
  - Form d = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry through a DIGIT-cell full-adder ripple.
  - sum_sh ← {d[DIGIT-1:0], sum_sh[WIDTH-1:DIGIT]}.
  - a_sh and b_sh shift right by DIGIT.
  - carry ← carry-out of the digit.
  - count++.
  - After the digit with count==NDIG-1, go to DONE.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry.
  - Both outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Inputs are not re-sampled after acceptance, so a and b may change freely during RUN.
- In IDLE, sum and cout keep the last completed result.
- Width rule: the result is exactly WIDTH+1 bits ({cout,sum}). There is no saturation.
- DIGIT==WIDTH is legal: a single RUN cycle. DIGIT==1 gives a pure bit-serial adder.

## Timing
- Reset values (rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, all internal registers 0. These take effect immediately on assertion, independent of clk.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No result is presented.
- Acceptance edge is E0. Digits are computed on edges E1..E_NDIG. out_valid rises after E_NDIG.
- Latency is NDIG cycles from acceptance to out_valid.
- If out_ready is already high, IDLE is re-entered at E_NDIG+1. The next operand can be accepted at E_NDIG+2 at the earliest.
- Peak throughput is one operation per NDIG+2 cycles.
- No same-cycle turnaround: in_ready is low in DONE even while out_ready=1.
- busy = !in_ready.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Ports sub and ovf exist.
  - On acceptance with sub=1, b is loaded inverted and carry is forced to 1. The result is a−b and cin is ignored; cout=1 means no borrow.
  - sub=0 behaves as normal add.
  - ovf = carry into bit WIDTH-1 XOR cout. It is captured in the last RUN cycle, valid with out_valid and held like sum.
- SERIAL_ADD_SUB_EN undefined:
  - Ports sub and ovf are absent. The block is add-only.

## Test plan
- Basic add (WIDTH=16, DIGIT=4): a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid must rise exactly 4 cycles after acceptance.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Separately, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum and cout stay stable and in_ready stays 0. An in_valid pulse during that window must be ignored.
- Reset mid-RUN: deassert rst_n 2 cycles after acceptance → out_valid=0, sum=0, in_ready=1 immediately. The next operation 0x0001+0x0001 must give 0x0002.
- Subtract (SERIAL_ADD_SUB_EN): 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0. 0x8000−0x0001 → sum=0x7FFF, ovf=1.
- Randomised: 1000 operations per configuration (DIGIT=1, 4, 16) with random handshake stalls. Each {cout,sum} must equal a+b+cin, and latency must equal NDIG.

Source files
------------

// File: rtl/digit_serial_adder.sv
// WIDTH-bit adder computing DIGIT bits per clock through a full-adder ripple and a registered carry.
// Optional SERIAL_ADD_SUB_EN adds the sub input and the signed-overflow output ovf.
module dsa_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q, sum_nxt;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] d;
    logic             last;

    // One digit of ripple; c[DIGIT] is the registered carry for the next digit.
    assign c[0] = carry;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            dsa_fa_cell u_fa (
                .a  (a_sh[i]),
                .b  (b_sh[i]),
                .ci (c[i]),
                .s  (d[i]),
                .co (c[i+1])
            );
        end
        if (DIGIT == WIDTH) begin : g_one_digit
            assign sum_nxt = d;
        end else begin : g_multi_digit
            assign sum_nxt = {d, sum_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign last = (cnt == CW'(NDIG - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh <= a;
            cnt  <= '0;
`ifdef SERIAL_ADD_SUB_EN
            b_sh  <= sub ? ~b : b;
            carry <= sub | cin;
`else
            b_sh  <= b;
            carry <= cin;
`endif
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            sum_sh <= sum_nxt;
            carry  <= c[DIGIT];
            cnt    <= cnt + CW'(1);
            // Result registers only change on the final digit so IDLE/RUN show the last result.
            if (last) begin
                sum_q  <= sum_nxt;
                cout_q <= c[DIGIT];
            end
        end
    end

`ifdef SERIAL_ADD_SUB_EN
    logic ovf_q;
    // Top bit of the final digit is bit WIDTH-1, so its carry-in vs carry-out gives signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf_q <= 1'b0;
        else if (state == RUN && last) ovf_q <= c[DIGIT-1] ^ c[DIGIT];
    end
    assign ovf = ovf_q;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
